// File: rtl/mem_ctrl_pkg.sv
// Shared types and geometry for the SRAM line-burst controller.
package mem_ctrl_pkg;

  localparam int LINE_WORDS = 8;
  localparam int WORD_BITS  = 32;
  localparam int LINE_BITS  = 256;
  localparam int BEAT_W     = 3;

  typedef enum logic [2:0] {
    IDLE,
    LAT,
    RBURST,
    RLAST,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/mem_line_assembler.sv
// 256-bit line buffer; one 32-bit lane is written per capture, selected by word index.
module mem_line_assembler
  import mem_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap_en,
  input  logic [BEAT_W-1:0]    cap_idx,
  input  logic [WORD_BITS-1:0] cap_data,
  output logic [LINE_BITS-1:0] line
);

  logic [LINE_WORDS-1:0] lane_we;

  always_comb begin
    lane_we = '0;
    if (cap_en) lane_we[cap_idx] = 1'b1;
  end

  // NOTE: the buffer is an ordinary register, not a RAM, so it can and must clear to zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line <= '0;
    end else begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        if (lane_we[k]) line[k*WORD_BITS +: WORD_BITS] <= cap_data;
      end
    end
  end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Line-read / word-write burst controller in front of a single-port SRAM.
// Define MEM_BURST_CTRL_WRAP_BURST_EN to start read bursts at the requested word and wrap.
module mem_burst_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ACCESS_LAT = 4,
  parameter int LINE_WORDS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_req_in,
  input  logic         mem_we_in,
  input  logic [31:0]  mem_addr_in,
  input  logic [31:0]  mem_wdata_in,
  input  logic [3:0]   mem_be_in,
  output logic [255:0] mem_rdata_out,
  output logic         mem_wait_out,
  output logic         sram_en_out,
  output logic         sram_we_out,
  output logic [31:0]  sram_addr_out,
  output logic [31:0]  sram_wdata_out,
  output logic [3:0]   sram_be_out,
  input  logic [31:0]  sram_rdata_in
);

  localparam logic [3:0]        LAT_LOAD  = (ACCESS_LAT == 0) ? 4'd0 : 4'(ACCESS_LAT - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  state_e              state, state_d;
  logic [3:0]          lat_cnt;
  logic [BEAT_W-1:0]   beat_cnt, beat_idx, start_idx, prev_idx;
  logic [31:2]         addr_q;
  logic                we_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic                cap_en;
  logic                addr_lsb_unused;

  // Byte offset within the word never reaches the SRAM.
  assign addr_lsb_unused = ^mem_addr_in[1:0];

`ifdef MEM_BURST_CTRL_WRAP_BURST_EN
  assign start_idx = addr_q[4:2];
`else
  assign start_idx = '0;
`endif

  // Beat-index width equals log2(LINE_WORDS), so the add wraps modulo the line.
  assign beat_idx = start_idx + beat_cnt;

  // NOTE: state and every other register use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d        = state;
    mem_wait_out   = 1'b1;
    sram_en_out    = 1'b0;
    sram_we_out    = 1'b0;
    sram_addr_out  = '0;
    sram_wdata_out = '0;
    sram_be_out    = '0;
    cap_en         = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req_in) begin
          if (ACCESS_LAT == 0) state_d = mem_we_in ? WRITE : RBURST;
          else                 state_d = LAT;
        end
      end
      LAT: begin
        if (lat_cnt == 4'd0) state_d = we_q ? WRITE : RBURST;
      end
      RBURST: begin
        sram_en_out   = 1'b1;
        sram_addr_out = {addr_q[31:5], beat_idx, 2'b00};
        // Data for the previous strobe arrives now; the first beat has none yet.
        cap_en        = (beat_cnt != '0);
        if (beat_cnt == LAST_BEAT) state_d = RLAST;
      end
      RLAST: begin
        cap_en  = 1'b1;
        state_d = DONE;
      end
      WRITE: begin
        sram_en_out    = 1'b1;
        sram_we_out    = 1'b1;
        sram_addr_out  = {addr_q, 2'b00};
        sram_wdata_out = wdata_q;
        sram_be_out    = be_q;
        state_d        = DONE;
      end
      DONE: begin
        mem_wait_out = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt  <= '0;
      beat_cnt <= '0;
      prev_idx <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req_in) begin
            addr_q   <= mem_addr_in[31:2];
            we_q     <= mem_we_in;
            wdata_q  <= mem_wdata_in;
            be_q     <= mem_be_in;
            lat_cnt  <= LAT_LOAD;
            beat_cnt <= '0;
          end
        end
        LAT: begin
          if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
        end
        RBURST: begin
          beat_cnt <= beat_cnt + 1'b1;
          prev_idx <= beat_idx;
        end
        default: ;
      endcase
    end
  end

  mem_line_assembler u_line (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (cap_en),
    .cap_idx  (prev_idx),
    .cap_data (sram_rdata_in),
    .line     (mem_rdata_out)
  );

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: two instances (ACCESS_LAT 4 and 0) against a transaction model.
`timescale 1ns/1ps
module tb_mem_burst_ctrl;

`ifdef MEM_BURST_CTRL_WRAP_BURST_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int LAT0 = 4;
  localparam int LAT1 = 0;
  localparam logic [255:0] LINE_40 =
    256'h00000017_00000016_00000015_00000014_00000013_00000012_00000011_00000010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         req    [2];
  logic         we_i   [2];
  logic [31:0]  addr_i [2];
  logic [31:0]  wd_i   [2];
  logic [3:0]   be_i   [2];
  logic [255:0] rdata_o[2];
  logic         wait_o [2];
  logic         en_o   [2];
  logic         swe_o  [2];
  logic [31:0]  saddr_o[2];
  logic [31:0]  swd_o  [2];
  logic [3:0]   sbe_o  [2];
  logic [31:0]  srd    [2];

  mem_burst_ctrl #(.ACCESS_LAT(LAT0), .LINE_WORDS(8)) u_dut0 (
    .clk(clk), .rst(rst), .mem_req_in(req[0]), .mem_we_in(we_i[0]), .mem_addr_in(addr_i[0]),
    .mem_wdata_in(wd_i[0]), .mem_be_in(be_i[0]), .mem_rdata_out(rdata_o[0]), .mem_wait_out(wait_o[0]),
    .sram_en_out(en_o[0]), .sram_we_out(swe_o[0]), .sram_addr_out(saddr_o[0]),
    .sram_wdata_out(swd_o[0]), .sram_be_out(sbe_o[0]), .sram_rdata_in(srd[0]));

  mem_burst_ctrl #(.ACCESS_LAT(LAT1), .LINE_WORDS(8)) u_dut1 (
    .clk(clk), .rst(rst), .mem_req_in(req[1]), .mem_we_in(we_i[1]), .mem_addr_in(addr_i[1]),
    .mem_wdata_in(wd_i[1]), .mem_be_in(be_i[1]), .mem_rdata_out(rdata_o[1]), .mem_wait_out(wait_o[1]),
    .sram_en_out(en_o[1]), .sram_we_out(swe_o[1]), .sram_addr_out(saddr_o[1]),
    .sram_wdata_out(swd_o[1]), .sram_be_out(sbe_o[1]), .sram_rdata_in(srd[1]));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit pat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM contents: word n = n for directed tests, a hash for random ones.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (pat) return (a * 32'h9E3779B1) ^ 32'hA5A5_0000;
    return a >> 2;
  endfunction

  // SRAM returns data one cycle after a read strobe; junk otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      srd[i] <= (en_o[i] && !swe_o[i]) ? memf(saddr_o[i]) : $urandom;
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k);
    int start;
    start = WRAP ? int'(a[4:2]) : 0;
    return {a[31:5], 5'b0} + 32'(4 * ((start + k) % 8));
  endfunction

  function automatic logic [255:0] build_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = memf({a[31:5], 5'b0} + 32'(4 * w));
    return l;
  endfunction

  // Transaction-level model state
  bit           busy     [2];
  bit           acc_flag [2];
  int           acc_cyc  [2];
  bit           op_we    [2];
  logic [31:0]  op_addr  [2];
  logic [31:0]  op_wd    [2];
  logic [3:0]   op_be    [2];
  logic [255:0] line_exp [2];

  // Observations of DUT behaviour for the directed literal checks
  int           obs_done_cyc[2];
  logic [255:0] obs_line    [2];
  int           n_strobes   [2];
  int           obs_st_cyc  [2];
  logic         obs_st_we   [2];
  logic [31:0]  obs_st_addr [2];
  logic [31:0]  obs_st_wd   [2];
  logic [3:0]   obs_st_be   [2];
  logic [31:0]  beat_q[$];

  task automatic model_step(input int i);
    logic        e_en, e_we, e_wait, chk_line, done_now;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    int          d, l;
    string       p;
    p = (i == 0) ? "u0" : "u1";
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0; e_be = '0;
    e_wait = 1'b1; chk_line = 1'b1; done_now = 1'b0;
    if (rst) begin
      busy[i] = 1'b0;
      line_exp[i] = '0;
    end else if (busy[i]) begin
      d = cyc - acc_cyc[i];
      l = lat_of(i);
      if (!op_we[i]) begin
        if (d >= l + 1 && d <= l + 8) begin
          e_en = 1'b1;
          e_addr = beat_addr(op_addr[i], d - l - 1);
          chk_line = 1'b0;
        end else if (d == l + 9) begin
          chk_line = 1'b0;
        end else if (d == l + 10) begin
          done_now = 1'b1;
          line_exp[i] = build_line(op_addr[i]);
        end
      end else begin
        if (d == l + 1) begin
          e_en = 1'b1; e_we = 1'b1; e_addr = {op_addr[i][31:2], 2'b00};
          e_wd = op_wd[i]; e_be = op_be[i];
        end else if (d == l + 2) begin
          done_now = 1'b1;
        end
      end
      if (done_now) e_wait = 1'b0;
    end
    check({p, " wait"}, wait_o[i], e_wait);
    check({p, " sram_en"}, en_o[i], e_en);
    check({p, " sram_we"}, swe_o[i], e_we);
    check({p, " sram_addr"}, saddr_o[i], e_addr);
    check({p, " sram_wdata"}, swd_o[i], e_wd);
    check({p, " sram_be"}, sbe_o[i], e_be);
    if (chk_line) check({p, " rdata"}, rdata_o[i], line_exp[i]);
    if (!rst) begin
      if (!wait_o[i]) begin
        obs_done_cyc[i] = cyc;
        obs_line[i] = rdata_o[i];
      end
      if (en_o[i]) begin
        n_strobes[i]++;
        obs_st_cyc[i] = cyc; obs_st_we[i] = swe_o[i]; obs_st_addr[i] = saddr_o[i];
        obs_st_wd[i] = swd_o[i]; obs_st_be[i] = sbe_o[i];
        if (i == 0) beat_q.push_back(saddr_o[i]);
      end
      if (done_now) begin
        busy[i] = 1'b0;
      end else if (!busy[i] && req[i]) begin
        busy[i] = 1'b1; acc_flag[i] = 1'b1; acc_cyc[i] = cyc;
        op_we[i] = we_i[i]; op_addr[i] = addr_i[i]; op_wd[i] = wd_i[i]; op_be[i] = be_i[i];
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  // Present a request until accepted, then scramble the inputs to prove they are ignored.
  task automatic issue(input int i, input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input int hold);
    int n;
    n = 0;
    acc_flag[i] = 1'b0;
    req[i] = 1'b1; we_i[i] = we; addr_i[i] = a; wd_i[i] = d; be_i[i] = be;
    while (!acc_flag[i] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("u%0d accept", i), acc_flag[i], 1'b1);
    we_i[i] = 1'($urandom); addr_i[i] = $urandom; wd_i[i] = $urandom; be_i[i] = 4'($urandom);
    req[i] = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
    end
    req[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (busy[i] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("u%0d completion", i), busy[i], 1'b0);
  endtask

  task automatic stream(input int i, input int n_ops);
    for (int k = 0; k < n_ops; k++) begin
      issue(i, 1'($urandom), $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom), $urandom_range(0, 1));
      wait_idle(i);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  logic [31:0] exp_beats [8];
  int s0, rd_done, rd_acc;

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we_i[i] = 1'b0; addr_i[i] = '0; wd_i[i] = '0; be_i[i] = '0;
      obs_done_cyc[i] = -1; n_strobes[i] = 0;
    end
    if (WRAP) exp_beats = '{32'h5C, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58};
    else      exp_beats = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58, 32'h5C};

    repeat (3) @(posedge clk);
    #1;
    check("reset wait", wait_o[0], 1'b1);
    check("reset sram_en", en_o[0], 1'b0);
    check("reset rdata", rdata_o[0], 256'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Line read at 0x40, ACCESS_LAT=4
    s0 = n_strobes[0];
    issue(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1);
    wait_idle(0);
    check("read latency", obs_done_cyc[0] - acc_cyc[0], 14);
    check("read line", obs_line[0], LINE_40);
    check("read lane0", obs_line[0][31:0], 32'h10);
    check("read beat count", n_strobes[0] - s0, 8);

    // Word write with partial byte enables
    issue(0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'b0011, 1);
    wait_idle(0);
    check("write strobe cycle", obs_st_cyc[0] - acc_cyc[0], 5);
    check("write strobe we", obs_st_we[0], 1'b1);
    check("write strobe addr", obs_st_addr[0], 32'h104);
    check("write strobe be", obs_st_be[0], 4'h3);
    check("write strobe data", obs_st_wd[0], 32'hDEAD_BEEF);
    check("write latency", obs_done_cyc[0] - acc_cyc[0], 6);
    check("write keeps line", obs_line[0], LINE_40);

    // Read at 0x5C: beat order depends on wrap build, layout must not
    beat_q.delete();
    issue(0, 1'b0, 32'h0000_005C, 32'h0, 4'h0, 0);
    wait_idle(0);
    check("wrap beat count", beat_q.size(), 8);
    for (int k = 0; k < 8 && k < beat_q.size(); k++)
      check($sformatf("beat %0d addr", k), beat_q[k], exp_beats[k]);
    check("wrap line", obs_line[0], LINE_40);
    check("wrap latency", obs_done_cyc[0] - acc_cyc[0], 14);

    // ACCESS_LAT=0 read, then write accepted in the very next IDLE cycle
    issue(1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0);
    wait_idle(1);
    rd_done = obs_done_cyc[1];
    rd_acc  = acc_cyc[1];
    check("lat0 read latency", rd_done - rd_acc, 10);
    check("lat0 read line", obs_line[1], LINE_40);
    issue(1, 1'b1, 32'h0000_0208, 32'h1234_5678, 4'b0000, 0);
    check("b2b accept", acc_cyc[1] - rd_done, 1);
    wait_idle(1);
    check("b2b strobe cycle", obs_st_cyc[1] - rd_done, 2);
    check("b2b be zero strobe", obs_st_addr[1], 32'h208);
    check("b2b write done", obs_done_cyc[1] - rd_done, 3);

    // Reset pulse during beat 3 of a read
    issue(0, 1'b0, 32'h0000_0080, 32'h0, 4'h0, 0);
    while (cyc < acc_cyc[0] + LAT0 + 4) begin
      @(posedge clk); #1;
    end
    check("beat3 addr", saddr_o[0], 32'h8C);
    obs_done_cyc[0] = -1;
    #2 rst = 1'b1;
    #1;
    check("abort sram_en", en_o[0], 1'b0);
    check("abort wait", wait_o[0], 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
    end
    check("abort no done", obs_done_cyc[0], -1);
    issue(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0);
    wait_idle(0);
    check("post-reset latency", obs_done_cyc[0] - acc_cyc[0], 14);
    check("post-reset line", obs_line[0], LINE_40);

    // Request dropped during LAT
    issue(0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 2);
    wait_idle(0);
    check("drop latency", obs_done_cyc[0] - acc_cyc[0], 14);
    s0 = n_strobes[0];
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("drop no restart", n_strobes[0] - s0, 0);

    // Randomised traffic on both instances concurrently
    pat = 1'b1;
    fork
      stream(0, 30);
      stream(1, 40);
    join
    repeat (4) begin
      @(posedge clk); #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: time %0t reached, expected completion earlier", $time);
    $fatal(1);
  end

endmodule

// File: doc/mem_burst_ctrl.md
MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 The block SHALL have parameter ACCESS_LAT, default 4: initial-latency cycles before any SRAM access (legal 0..15).
REQ-002 The block SHALL have parameter LINE_WORDS, default 8: number of 32-bit beats per line.
REQ-003 The block SHALL have the following ports:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req_in  in  1  access request from the bus arbiter.
- mem_we_in  in  1  1 = word write, 0 = line read.
- mem_addr_in  in  32  byte address.
- mem_wdata_in  in  32  write word.
- mem_be_in  in  4  write byte enables.
- mem_rdata_out  out  256  assembled line, word k in bits [32k+31:32k].
- mem_wait_out  out  1  0 only in the completion cycle.
- sram_en_out  out  1  SRAM access strobe.
- sram_we_out  out  1  SRAM write.
- sram_addr_out  out  32  word-aligned byte address.
- sram_wdata_out  out  32  SRAM write data.
- sram_be_out  out  4  SRAM byte enables.
- sram_rdata_in  in  32  SRAM read data, valid one cycle after a read strobe.

Function
REQ-004 The block SHALL have FSM states IDLE, LAT, RBURST, RLAST, WRITE, DONE.
REQ-005 In IDLE with mem_req_in=1, the block SHALL latch addr, we, wdata and be, and go to LAT; if ACCESS_LAT=0 it SHALL go directly to RBURST (read) or WRITE (write).
REQ-006 LAT SHALL last exactly ACCESS_LAT cycles using a 4-bit down-counter, then go to RBURST or WRITE.
REQ-007 RBURST SHALL last LINE_WORDS cycles, issuing one read strobe per cycle at line_base + 4*word_idx, where line_base = addr & ~0x1F.
REQ-008 Each RBURST cycle after the first SHALL capture sram_rdata_in into the lane of the previous beat.
REQ-009 RLAST SHALL capture the final beat with no strobe, then go to DONE.
REQ-010 WRITE SHALL issue one strobe with sram_we_out=1 to addr & ~0x3, with the latched wdata and be, then go to DONE.
REQ-011 DONE SHALL drive mem_wait_out=0 for exactly one cycle with mem_rdata_out stable, then return to IDLE unconditionally.
REQ-012 mem_wait_out SHALL be 1 in every state except DONE.
REQ-013 Read latency SHALL be ACCESS_LAT+10 cycles from the IDLE accept cycle to DONE; write latency SHALL be ACCESS_LAT+2 cycles.
REQ-014 mem_req_in SHALL be ignored outside IDLE; changes to the input address or data after acceptance SHALL have no effect.
REQ-015 If mem_req_in is dropped mid-operation, the operation SHALL still complete, including the DONE cycle.
REQ-016 A write with be=4'b0000 SHALL still issue the SRAM cycle.
REQ-017 mem_rdata_out SHALL hold the last completed line until the next read overwrites lanes; writes SHALL NOT modify it.
REQ-018 sram_* outputs SHALL be 0 whenever sram_en_out=0.

Reset
REQ-019 On rst=1, asynchronously: state=IDLE, counters=0, line buffer=0, mem_wait_out=1, all sram_* outputs=0, latched request registers=0.
REQ-020 Reset asserted mid-burst SHALL abort the burst with no DONE cycle; the first request after deassertion SHALL be serviced normally.

Configuration
REQ-021 With MEM_BURST_CTRL_WRAP_BURST_EN defined, the beat order SHALL start at addr[4:2] and wrap modulo LINE_WORDS, with lane placement still by word index.
REQ-022 Without MEM_BURST_CTRL_WRAP_BURST_EN, beats SHALL always run from word 0 to word 7.
REQ-023 Latency and line layout SHALL be identical in both configurations.

Structure
REQ-024 Package mem_ctrl_pkg SHALL hold the state enum, LINE_WORDS, LINE_BITS=256 and the beat-index width (3).
REQ-025 Sub-module mem_line_assembler SHALL own the 256-bit line buffer and its lane-write enable decode; the FSM and counters SHALL remain in mem_burst_ctrl.

Verification
REQ-026 The bench SHALL cover these scenarios:
- Read at 0x0000_0040, ACCESS_LAT=4, SRAM word n = n -> wait low at cycle 14, line = {0x17..0x10}, lane 0 = 0x10.
- Write 0x0000_0104, data 0xDEADBEEF, be 4'b0011 -> one strobe at cycle 5 with we=1, addr 0x104, be 0x3; wait low at cycle 6.
- Read 0x0000_005C with WRAP_EN -> beat addresses in order 0x5C, 0x40, 0x44 ... 0x58; line layout identical to the non-wrap run.
- ACCESS_LAT=0 read -> wait low at cycle 10; then a back-to-back write accepted in the next IDLE cycle.
- rst pulse in the RBURST cycle issuing beat 3 -> no DONE, sram_en=0 immediately; next read completes with full latency.
- mem_req_in dropped during LAT -> DONE still occurs, and no second access starts.
